// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   STAT_W      : width of each per-requester beat counter (stats build only)
//   rr_pick     : round-robin search; returns {found, index} of the first valid
//                 requester after ptr, wrapping modulo n (n <= MAX_REQ)
package fifo_wr_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 16;

  function automatic logic [4:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0]         ptr,
                                         input int unsigned        n);
    logic [4:0] r;
    logic [3:0] idx;
    r = '0;
    // k runs 1..n so the requester at ptr itself is checked last
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = 4'((32'(ptr) + k) % n);
      if (k <= n && !r[4] && valid[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_picker.sv
// Combinational round-robin selector.
//   valid : per-requester request bits
//   ptr   : index of the most recently served requester
//   idx   : winning requester index (meaningful only when found=1)
//   found : at least one requester is valid
module fifo_rr_picker
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     idx,
  output logic               found
);

  logic [MAX_REQ-1:0] valid_ext;
  logic [3:0]         ptr_ext;
  logic [4:0]         pick;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid;
    ptr_ext                  = '0;
    ptr_ext[IDW-1:0]         = ptr;
    pick                     = rr_pick(valid_ext, ptr_ext, NUM_REQ);
  end

  assign idx   = IDW'(pick[3:0]);
  assign found = pick[4];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// A producer keeps the grant for a burst, ended by its last beat or after
// MAX_BURST beats. Granted data passes to the FIFO with zero latency.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid/last/data/ready  per-requester valid/ready beat interface
//   fifo_full, fifo_occup      FIFO back-pressure inputs
//   fifo_wr_en, fifo_wr_data   FIFO write pins
//   grant_active, grant_id     current grant status / last grantee
// Optional build macro FIFO_WR_ARB_STATS_EN adds stat_clr (in) and
// stat_beats (out, NUM_REQ x 16-bit saturating beats-written counters).
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int MAX_BURST = 8,
  parameter int MIN_FREE  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  input  logic [$clog2(DEPTH):0]     fifo_occup,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_wr_data,
  output logic                       grant_active,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NUM_REQ*STAT_W-1:0]  stat_beats
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int OCW = $clog2(DEPTH) + 1;
  localparam logic [OCW-1:0] DEPTH_C    = OCW'(DEPTH);
  localparam logic [OCW-1:0] MIN_FREE_C = OCW'(MIN_FREE);
  localparam logic [7:0]     BURST_LAST = 8'(MAX_BURST - 1);

  arb_state_e     state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n;
  logic [IDW-1:0] grant_id_n;
  logic [7:0]     beat_cnt, beat_cnt_n;
  logic           bubble, bubble_n;
  logic [OCW-1:0] free;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           xfer;

  assign free         = DEPTH_C - fifo_occup;
  assign grant_active = (state == GRANT);

  fifo_rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    req_ready    = '0;
    xfer         = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    state_n      = state;
    rr_ptr_n     = rr_ptr;
    grant_id_n   = grant_id;
    beat_cnt_n   = beat_cnt;
    bubble_n     = bubble;
    case (state)
      IDLE: begin
        // The first IDLE cycle after a release is a dead bubble, so a
        // burst costs MAX_BURST+2 cycles under contention.
        bubble_n = 1'b0;
        if (!bubble && pick_found && free >= MIN_FREE_C && !fifo_full) begin
          state_n    = GRANT;
          grant_id_n = pick_idx;
          beat_cnt_n = '0;
        end
      end
      GRANT: begin
        req_ready[grant_id] = !fifo_full;
        xfer = req_valid[grant_id] & !fifo_full;
        if (xfer) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = req_data[grant_id*WIDTH +: WIDTH];
          beat_cnt_n   = beat_cnt + 8'd1;
          if (req_last[grant_id] || beat_cnt == BURST_LAST) begin
            state_n  = IDLE;
            rr_ptr_n = grant_id;
            bubble_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= IDW'(NUM_REQ - 1);
      grant_id <= '0;
      beat_cnt <= '0;
      bubble   <= 1'b0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      grant_id <= grant_id_n;
      beat_cnt <= beat_cnt_n;
      bubble   <= bubble_n;
    end
  end

  // Occupancy above DEPTH would wrap the free-space subtraction.
  assert property (@(posedge clk) disable iff (rst) fifo_occup <= DEPTH_C);

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    logic [STAT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (rst || stat_clr)
        cnt <= '0;
      else if (xfer && grant_id == IDW'(i) && cnt != '1)
        cnt <= cnt + 1'b1;
    end
    assign stat_beats[i*STAT_W +: STAT_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter. Producer queues feed the request
// ports; a per-requester scoreboard holds the beats expected at the FIFO.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 32;
  localparam int DEPTH     = 16;
  localparam int MAX_BURST = 8;
  localparam int MIN_FREE  = 4;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_last;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full = 1'b0;
  logic [4:0]               fifo_occup = '0;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic                     grant_active;
  logic [1:0]               grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
  logic                     stat_clr = 1'b0;
  logic [NUM_REQ*16-1:0]    stat_beats;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .MAX_BURST(MAX_BURST), .MIN_FREE(MIN_FREE)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_occup(fifo_occup),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .grant_active(grant_active), .grant_id(grant_id)
`ifdef FIFO_WR_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_beats(stat_beats)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  beat_t            src   [NUM_REQ][$];
  logic [WIDTH-1:0] exp_q [NUM_REQ][$];
  int               wcnt  [NUM_REQ];
  int               glog  [$];
  int               blen  [$];
  int               wlog  [$];
  int               cyc = 0;
  int               seq_n = 1;
  logic             prev_ga = 1'b0;
  logic [NUM_REQ-1:0] hs;

  // Producer driver and FIFO-side monitor: sample at negedge, drive 1 after posedge.
  initial begin
    logic [WIDTH-1:0] expd;
    int id;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      hs = req_valid & req_ready;
      if (grant_active && !prev_ga) begin
        glog.push_back(int'(grant_id));
        blen.push_back(0);
      end
      prev_ga = grant_active;
      if (fifo_wr_en === 1'b1) begin
        checks++;
        if (fifo_full !== 1'b0) begin
          errors++;
          $display("FAIL wr_en_while_full: wr_en=1 with fifo_full=%b at cycle %0d", fifo_full, cyc);
        end
        id = int'(fifo_wr_data[31:28]);
        checks++;
        if (id >= NUM_REQ || exp_q[id].size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: wrote %h, nothing expected", fifo_wr_data);
        end else begin
          expd = exp_q[id].pop_front();
          if (fifo_wr_data !== expd) begin
            errors++;
            $display("FAIL scoreboard_data: got %h, expected %h", fifo_wr_data, expd);
          end
          wcnt[id]++;
        end
        wlog.push_back(cyc);
        if (blen.size() > 0) blen[blen.size()-1]++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++)
        if (hs[i] && src[i].size() > 0) void'(src[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
        if (src[i].size() > 0) begin
          req_valid[i]                = 1'b1;
          req_data[i*WIDTH +: WIDTH]  = src[i][0].data;
          req_last[i]                 = src[i][0].last;
        end else begin
          req_valid[i]                = 1'b0;
          req_data[i*WIDTH +: WIDTH]  = '0;
          req_last[i]                 = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_beats(input int id, input int n, input bit last_at_end);
    beat_t b;
    logic [31:0] tag;
    for (int k = 0; k < n; k++) begin
      tag    = 32'(id);
      b.data = {tag[3:0], 28'(seq_n)};
      seq_n++;
      b.last = last_at_end && (k == n - 1);
      src[id].push_back(b);
      exp_q[id].push_back(b.data);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #2;
    rst        = 1'b1;
    fifo_full  = 1'b0;
    fifo_occup = '0;
    req_valid  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src[i].delete();
      exp_q[i].delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    glog.delete();
    blen.delete();
    wlog.delete();
    for (int i = 0; i < NUM_REQ; i++) wcnt[i] = 0;
    rst = 1'b0;
  endtask

  task automatic wait_writes(input int id, input int n, input int budget, output bit ok);
    int k;
    k  = 0;
    ok = 1'b1;
    while (wcnt[id] < n) begin
      if (k >= budget) begin
        ok = 1'b0;
        break;
      end
      @(posedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int k;
    for (int i = 0; i < NUM_REQ; i++) push_beats(i, 1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || fifo_wr_en !== 1'b0 || fifo_wr_data !== '0 ||
          grant_active !== 1'b0 || grant_id !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%b wr_en=%b data=%h ga=%b gid=%0d, expected all 0",
                 req_ready, fifo_wr_en, fifo_wr_data, grant_active, grant_id);
      end
    end
    checks++;
    if (req_valid !== 4'hF) begin
      errors++;
      $display("FAIL reset_valid_setup: req_valid=%b expected 1111", req_valid);
    end
    release_reset();
    k = 0;
    while (grant_active !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (grant_active !== 1'b1 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_first_grant: ga=%b gid=%0d, expected ga=1 gid=0", grant_active, grant_id);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      wait_writes(i, 1, 60, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL reset_drain: req%0d wrote %0d beats, expected 1", i, wcnt[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    push_beats(0, 1, 1'b1);
    push_beats(0, 1, 1'b1);
    for (int i = 1; i < NUM_REQ; i++) push_beats(i, 1, 1'b1);
    release_reset();
    wait_writes(0, 2, 80, ok);
    repeat (2) @(posedge clk);
    checks++;
    if (!ok || glog.size() != 5) begin
      errors++;
      $display("FAIL rr_grant_count: ok=%b grants=%0d, expected 5", ok, glog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (glog[i] != exp_g[i] || blen[i] != 1) begin
          errors++;
          $display("FAIL rr_sequence[%0d]: gid=%0d beats=%0d, expected gid=%0d beats=1",
                   i, glog[i], blen[i], exp_g[i]);
        end
      end
      for (int i = 1; i < wlog.size(); i++) begin
        checks++;
        if (wlog[i] - wlog[i-1] != 3) begin
          errors++;
          $display("FAIL rr_spacing[%0d]: %0d cycles between beats, expected 3",
                   i, wlog[i] - wlog[i-1]);
        end
      end
    end
  endtask

  task automatic test_burst_limit();
    bit ok;
    int exp_l [3] = '{8, 8, 4};
    int exp_g [4] = '{0, 2, 0, 2};
    int exp_b [4] = '{1, 8, 1, 8};
    apply_reset();
    push_beats(2, 20, 1'b0);
    release_reset();
    wait_writes(2, 20, 150, ok);
    repeat (5) @(posedge clk);
    checks++;
    if (!ok || glog.size() != 3 || grant_active !== 1'b1) begin
      errors++;
      $display("FAIL burst_single: ok=%b grants=%0d ga=%b, expected 3 grants still active",
               ok, glog.size(), grant_active);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (glog[i] != 2 || blen[i] != exp_l[i]) begin
          errors++;
          $display("FAIL burst_len[%0d]: gid=%0d beats=%0d, expected gid=2 beats=%0d",
                   i, glog[i], blen[i], exp_l[i]);
        end
      end
    end
    apply_reset();
    push_beats(2, 16, 1'b0);
    push_beats(0, 1, 1'b1);
    push_beats(0, 1, 1'b1);
    release_reset();
    wait_writes(2, 16, 150, ok);
    repeat (3) @(posedge clk);
    checks++;
    if (!ok || glog.size() != 4) begin
      errors++;
      $display("FAIL burst_mixed_count: ok=%b grants=%0d, expected 4", ok, glog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (glog[i] != exp_g[i] || blen[i] != exp_b[i]) begin
          errors++;
          $display("FAIL burst_mixed[%0d]: gid=%0d beats=%0d, expected gid=%0d beats=%0d",
                   i, glog[i], blen[i], exp_g[i], exp_b[i]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    bit ok;
    apply_reset();
    push_beats(1, 6, 1'b1);
    release_reset();
    wait_writes(1, 2, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_start: wrote %0d beats, expected 2", wcnt[1]);
    end
    #2;
    fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (req_ready !== '0 || fifo_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: ready=%b wr_en=%b, expected 0000/0", req_ready, fifo_wr_en);
      end
    end
    @(posedge clk);
    #2;
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume: ready=%b wr_en=%b, expected 0010/1", req_ready, fifo_wr_en);
    end
    wait_writes(1, 6, 40, ok);
    repeat (2) @(posedge clk);
    checks++;
    if (!ok || exp_q[1].size() != 0 || glog.size() != 1 || blen[0] != 6) begin
      errors++;
      $display("FAIL stall_complete: written=%0d pending=%0d grants=%0d, expected 6/0/1",
               wcnt[1], exp_q[1].size(), glog.size());
    end
  endtask

  task automatic test_min_free();
    bit ok;
    apply_reset();
    fifo_occup = 5'd13;
    push_beats(3, 1, 1'b1);
    release_reset();
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (grant_active !== 1'b0 || req_ready !== '0) begin
        errors++;
        $display("FAIL minfree_block: ga=%b ready=%b at occup=13, expected 0", grant_active, req_ready);
      end
    end
    @(posedge clk);
    #2;
    fifo_occup = 5'd12;
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b0) begin
      errors++;
      $display("FAIL minfree_same_cycle: ga=%b, expected 0", grant_active);
    end
    @(negedge clk);
    checks++;
    if (grant_active !== 1'b1 || grant_id !== 2'd3) begin
      errors++;
      $display("FAIL minfree_grant: ga=%b gid=%0d, expected ga=1 gid=3", grant_active, grant_id);
    end
    wait_writes(3, 1, 20, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL minfree_write: wrote %0d beats, expected 1", wcnt[3]);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    apply_reset();
    push_beats(1, 6, 1'b1);
    release_reset();
    wait_writes(1, 3, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midrst_start: wrote %0d beats, expected 3", wcnt[1]);
    end
    #2;
    rst       = 1'b1;
    req_valid = '0;
    src[1].delete();
    exp_q[1].delete();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== '0 || fifo_wr_en !== 1'b0 || grant_active !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle: ready=%b wr_en=%b ga=%b, expected all 0",
               req_ready, fifo_wr_en, grant_active);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    checks++;
    if (stat_beats !== '0) begin
      errors++;
      $display("FAIL midrst_stats: stat_beats=%h, expected 0", stat_beats);
    end
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    checks++;
    if (wcnt[1] != 3 || glog.size() != 1) begin
      errors++;
      $display("FAIL midrst_truncate: written=%0d grants=%0d, expected 3/1", wcnt[1], glog.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) wcnt[i] = 0;
    test_reset();
    test_round_robin();
    test_burst_limit();
    test_full_stall();
    test_min_free();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
